alu_serial_32bit: RTL and testbench
===================================

# alu_serial_32bit

Bit-serial 32-bit ALU for the MIPS datapath. Processes one bit per clock, LSB first, with a registered carry between bit steps. Accepts a 32-bit operand pair and a 3-bit opcode through a start/done handshake. Returns the 32-bit result with zero, carry-out and overflow flags for the downstream writeback/branch logic.

## Interface
- Parameters: none; width fixed at 32, opcode at 3 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  32  operand A; latched on accepted start
- b  in  32  operand B; latched on accepted start
- op  in  3  opcode; latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  high for exactly one cycle, in DONE
- result  out  32  final result; holds until next DONE
- zero  out  1  result == 0
- cout  out  1  carry out of bit 31 (ADD/SUB only, else 0)
- overflow  out  1  signed overflow (ADD/SUB only, else 0)

## Operation
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB (A + ~B + 1), 111 SLT (signed A < B).
- Opcodes 011, 100 and 101 are invalid: the block runs the full 32 steps, then result = 0 and all flags = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a, b, op
  - bit counter = 0
  - carry = op[2]
  - next state RUN
- RUN, each cycle:
  - compute bit[cnt] from a[cnt], b[cnt] (b inverted when op[2]=1) and carry
  - shift the bit into the internal shift register MSB-first (shift right, insert at bit 31)
  - update carry (ADD/SUB/SLT)
  - increment cnt
- RUN, at cnt=31 (same edge as the last bit):
  - write the output registers
  - result = full shift value, or {31'b0, sum31 ^ ovf} for SLT
  - ovf = carry-in(bit31) ^ carry-out(bit31)
  - zero computed from the written result
  - cout and overflow written for ADD/SUB; 0 for AND/OR/SLT/invalid
  - next state DONE
- DONE: done=1 for one cycle.
  - start=1: latch the new operands and go to RUN (back-to-back accept).
  - start=0: go to IDLE.
- start while in RUN is ignored; the latched operands are unaffected.
- Output registers change only on the last-bit edge or on reset.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, result=0, zero=0, cout=0, overflow=0, cnt=0, carry=0.
  - Reset mid-RUN discards the operation; no done is produced.
- Accept edge E0: busy=1 from E0.
- Bit i is processed at edge E(i+1). Edge E32 writes the outputs and enters DONE.
- done=1 and busy=0 in the cycle after E32. Latency from accept edge to done visible: 32 cycles.
- Back-to-back throughput: one operation per 33 cycles.
- busy and done are never high together.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001:
  - result=0x80000000, overflow=1, cout=0, zero=0
  - done high exactly 32 cycles after the accept edge, for one cycle only
- SUB a=5, b=5 -> result=0, zero=1, cout=1, overflow=0.
- SLT cases:
  - a=0xFFFFFFFF, b=1 -> result=1
  - a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow-correction path); cout=0, overflow=0
- Logic ops on a=0xF0F0F0F0, b=0x0FF00FF0:
  - AND -> 0x00F000F0
  - OR -> 0xFFF0FFF0
  - cout=0, overflow=0 for both
- Start ignored while busy: pulse start with new operands at bit 5 -> result is unchanged from the original op.
- Reset and back-to-back:
  - rst_n low at bit 10 -> all outputs 0, IDLE, no done pulse
  - next ADD 3+4 -> result=7
  - start asserted during DONE -> immediate accept; second result correct 33 cycles after the first accept edge

Source files
------------

// File: rtl/alu_serial_32bit.sv
// Bit-serial 32-bit ALU: one result bit per clock, LSB first, with a registered carry.
// Handshake: start is accepted in IDLE or DONE; busy marks RUN; done pulses one cycle.
module alu_serial_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state, state_nx;
  logic [31:0] a_q, b_q, sh_q;
  logic [2:0]  op_q;
  logic [4:0]  cnt;
  logic        carry;

  logic        a_bit, b_bit, sum_bit, carry_nx, res_bit, ovf;
  logic        accept, last, arith, uses_carry, valid_op;
  logic [31:0] final_res;

  always_comb begin
    a_bit      = a_q[cnt];
    // SUB and SLT compute A + ~B + 1: B is inverted and carry starts at op[2].
    b_bit      = b_q[cnt] ^ op_q[2];
    sum_bit    = a_bit ^ b_bit ^ carry;
    carry_nx   = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    ovf        = carry ^ carry_nx;
    arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
    uses_carry = arith || (op_q == OP_SLT);
    valid_op   = uses_carry || (op_q == OP_AND) || (op_q == OP_OR);
    accept     = start && (state == IDLE || state == DONE);
    last       = (state == RUN) && (cnt == 5'd31);

    res_bit = sum_bit;
    case (op_q)
      OP_AND:  res_bit = a_q[cnt] & b_q[cnt];
      OP_OR:   res_bit = a_q[cnt] | b_q[cnt];
      default: res_bit = sum_bit;
    endcase

    // SLT corrects the sign of the difference with the overflow of bit 31.
    if (!valid_op)
      final_res = 32'd0;
    else if (op_q == OP_SLT)
      final_res = {31'd0, sum_bit ^ ovf};
    else
      final_res = {res_bit, sh_q[31:1]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 3'd0;
      sh_q     <= 32'd0;
      cnt      <= 5'd0;
      carry    <= 1'b0;
      result   <= 32'd0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        cnt   <= 5'd0;
        carry <= op[2];
      end else if (state == RUN) begin
        sh_q <= {res_bit, sh_q[31:1]};
        cnt  <= cnt + 5'd1;
        if (uses_carry) carry <= carry_nx;
        if (last) begin
          result   <= final_res;
          zero     <= valid_op && (final_res == 32'd0);
          cout     <= arith && carry_nx;
          overflow <= arith && ovf;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_serial_32bit.sv
// Bench for alu_serial_32bit: a reference model fills an expected queue at each
// accepted start; a monitor pops and compares on every done pulse.
module tb_alu_serial_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done, zero, cout, overflow;
  logic [31:0] result;
  logic [1:0]  fsm_state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned done_seen = 0;
  logic [34:0] exp_q[$];

  alu_serial_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: {result, zero, cout, overflow}
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] o);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v, z;
    r = 32'd0; c = 1'b0; v = 1'b0; s = 33'd0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    z = (o == 3'b011 || o == 3'b100 || o == 3'b101) ? 1'b0 : (r == 32'd0);
    return {r, z, c, v};
  endfunction

  // scoreboard monitor
  always @(posedge clk) begin
    logic [34:0] e;
    #1;
    if (done) begin
      done_seen++;
      check("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",   result,          e[34:3]);
        check("zero",     {31'd0, zero},     {31'd0, e[2]});
        check("cout",     {31'd0, cout},     {31'd0, e[1]});
        check("overflow", {31'd0, overflow}, {31'd0, e[0]});
      end
    end
  end

  // driver tasks (called away from the clock edge)
  task automatic check_idle_outputs(input string tag);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, {28'd0, zero, cout, overflow, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    a = x; b = y; op = o; start = 1'b1;
    exp_q.push_back(model(x, y, o));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    int n;
    apply(x, y, o);
    wait_done(n);
    check("latency", n, 32'd32);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int unsigned d;
    start = 1'b0; a = 32'd0; b = 32'd0; op = 3'd0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
    run_op(32'd5, 32'd5, 3'b110);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b111);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b111);
    run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000);
    run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    run_op(32'd0, 32'd1, 3'b110);

    // start pulse during RUN must be ignored
    apply(32'h1234_5678, 32'h1111_1111, 3'b010);
    repeat (5) @(posedge clk);
    #1;
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; op = 3'b110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("latency_ignored_start", n, 32'd26);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)));

    // reset in the middle of an operation
    apply(32'd1, 32'd2, 3'b010);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    d = done_seen;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen, d);

    // back-to-back accept from DONE
    apply(32'd3, 32'd4, 3'b010);
    wait_done(n);
    check("b2b_first_latency", n, 32'd32);
    apply(32'hDEAD_BEEF, 32'h1234_5678, 3'b110);
    wait_done(n);
    check("b2b_second_latency", n, 32'd32);
    @(posedge clk); #1;
    check("b2b_done_one_cycle", {31'd0, done}, 32'd0);

    check("queue_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
